// File: rtl/row_renderer.sv
`default_nettype none
// row_renderer rev 1.0: clears a line buffer to BG_COLOR, then paints entity squares covering the row in table order.
// Optional macro ROW_RENDERER_TRANSPARENT_EN: entities coloured TRANSPARENT_KEY are skipped.
module row_renderer #(
  parameter int XW = 9,
  parameter int ROW_LEN = 320,
  parameter int YW = 8,
  parameter int SW = 5,
  parameter int CW = 24,
  parameter int ENT_AW = 8,
  parameter logic [CW-1:0] BG_COLOR = 24'h000000,
  parameter logic [CW-1:0] TRANSPARENT_KEY = 24'hFF00FF,
  localparam int ENT_W = CW + SW + YW + XW
) (
  input  logic              clock,
  input  logic              reset_reset,
  input  logic              row_start,
  input  logic              screen_start,
  input  logic [ENT_AW:0]   entities_number,
  output logic [ENT_AW-1:0] ent_addr,
  input  logic [ENT_W-1:0]  ent_data,
  output logic [XW-1:0]     wr_addr,
  output logic [CW-1:0]     wr_data,
  output logic              wren,
  output logic              busy,
  output logic              row_done,
  output logic [YW-1:0]     cur_row,
  output logic              overrun
);

  localparam logic [XW:0]   LEN     = (XW+1)'(ROW_LEN);
  localparam logic [XW-1:0] LAST_PX = XW'(ROW_LEN - 1);

`ifdef ROW_RENDERER_TRANSPARENT_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_FETCH, S_CHECK, S_DRAW, S_DONE
  } state_t;

  state_t          state;
  logic [XW-1:0]   px;
  logic [XW:0]     px_end;
  logic [ENT_AW:0] n_ent;
  logic [CW-1:0]   draw_color;
  logic            zero_pending;

  logic [XW-1:0] ent_x;
  logic [YW-1:0] ent_y;
  logic [SW-1:0] ent_side;
  logic [CW-1:0] ent_color;
  logic [YW:0]   y_end;
  logic [XW:0]   x_end;
  logic [XW:0]   clip_end;
  logic          y_hit;
  logic          x_ok;
  logic          keyed;
  logic          hit;
  logic          last_ent;

  assign {ent_color, ent_side, ent_y, ent_x} = ent_data;

  // Sums are one bit wider than their operands so squares near the edge never wrap.
  assign y_end    = {1'b0, ent_y} + (YW+1)'(ent_side);
  assign x_end    = {1'b0, ent_x} + (XW+1)'(ent_side);
  assign clip_end = (x_end > LEN) ? LEN : x_end;
  assign y_hit    = (ent_side != '0) && (cur_row >= ent_y) && ({1'b0, cur_row} < y_end);
  assign x_ok     = ({1'b0, ent_x} < LEN);
  assign keyed    = KEY_EN && (ent_color == TRANSPARENT_KEY);
  assign hit      = y_hit && x_ok && !keyed;
  assign last_ent = ({1'b0, ent_addr} == (n_ent - (ENT_AW+1)'(1)));

  always_ff @(posedge clock or negedge reset_reset) begin
    if (!reset_reset) begin
      state        <= S_IDLE;
      px           <= '0;
      px_end       <= '0;
      n_ent        <= '0;
      draw_color   <= '0;
      zero_pending <= 1'b1;
      ent_addr     <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      wren         <= 1'b0;
      busy         <= 1'b0;
      row_done     <= 1'b0;
      cur_row      <= '0;
      overrun      <= 1'b0;
    end else begin
      wren     <= 1'b0;
      row_done <= 1'b0;
      if (screen_start) begin
        overrun      <= 1'b0;
        zero_pending <= 1'b1;
      end
      // A row_start while busy aborts the current row and starts the next one from CLEAR.
      if (row_start) begin
        if (state != S_IDLE) overrun <= 1'b1;
        cur_row      <= (screen_start || zero_pending) ? '0 : cur_row + YW'(1);
        zero_pending <= 1'b0;
        n_ent        <= entities_number;
        px           <= '0;
        busy         <= 1'b1;
        state        <= S_CLEAR;
      end else begin
        case (state)
          S_IDLE: ;
          S_CLEAR: begin
            wren    <= 1'b1;
            wr_addr <= px;
            wr_data <= BG_COLOR;
            px      <= px + XW'(1);
            if (px == LAST_PX) begin
              ent_addr <= '0;
              state    <= (n_ent == '0) ? S_DONE : S_FETCH;
            end
          end
          S_FETCH: state <= S_CHECK;
          S_CHECK: begin
            if (hit) begin
              px         <= ent_x;
              px_end     <= clip_end;
              draw_color <= ent_color;
              state      <= S_DRAW;
            end else if (last_ent) begin
              state <= S_DONE;
            end else begin
              ent_addr <= ent_addr + ENT_AW'(1);
              state    <= S_FETCH;
            end
          end
          S_DRAW: begin
            wren    <= 1'b1;
            wr_addr <= px;
            wr_data <= draw_color;
            px      <= px + XW'(1);
            if (({1'b0, px} + (XW+1)'(1)) == px_end) begin
              if (last_ent) begin
                state <= S_DONE;
              end else begin
                ent_addr <= ent_addr + ENT_AW'(1);
                state    <= S_FETCH;
              end
            end
          end
          S_DONE: begin
            busy     <= 1'b0;
            row_done <= 1'b1;
            state    <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire
